pwm_level_sequencer: RTL and testbench

//  Upstream driver for the signed 6-bit PWM stage. Accepts queued (level, hold) commands, then slews

---
 rtl/pwm_pkg.sv | 49 ++++
 rtl/pwm_level_sequencer_if.sv | 10 +
 rtl/pwm_cmd_fifo.sv | 56 +++++
 rtl/pwm_level_sequencer.sv | 122 ++++++++++++
 tb/tb_pwm_level_sequencer.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM stage and its level sequencer: defaults,
// FSM state encoding, command record and the clamp/slew arithmetic.
package pwm_pkg;

  localparam int PWM_UNIT_DEF  = 100;
  localparam int PWM_STEPS_DEF = 15;
  localparam int MAX_LEVEL_DEF = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic signed [5:0] level;
    logic [7:0]        hold;
  } cmd_t;

  function automatic logic signed [5:0] clamp_level(input logic signed [7:0] lvl,
                                                    input logic signed [7:0] lim);
    if (lvl > lim)       return lim[5:0];
    else if (lvl < -lim) return 6'(-lim);
    else                 return lvl[5:0];
  endfunction

  function automatic logic is_clamped(input logic signed [7:0] lvl,
                                      input logic signed [7:0] lim);
    return (lvl > lim) || (lvl < -lim);
  endfunction

  // Move cur toward tgt by at most slew; the difference is taken at 8 bits so it cannot wrap.
  function automatic logic signed [5:0] step_level(input logic signed [5:0] cur,
                                                   input logic signed [5:0] tgt,
                                                   input logic [7:0]        slew);
    logic [7:0] cur_x;
    logic [7:0] diff;
    logic [7:0] mag;
    logic [7:0] res;
    cur_x = {{2{cur[5]}}, cur};
    diff  = {{2{tgt[5]}}, tgt} - cur_x;
    mag   = diff[7] ? (8'd0 - diff) : diff;
    if (mag <= slew)  res = {{2{tgt[5]}}, tgt};
    else if (diff[7]) res = cur_x - slew;
    else              res = cur_x + slew;
    return res[5:0];
  endfunction

endpackage

// File: rtl/pwm_level_sequencer_if.sv
// Command handshake between a command source and the level sequencer.
interface pwm_level_sequencer_if;
  logic              cmd_valid;
  logic              cmd_ready;
  logic signed [7:0] cmd_level;
  logic [7:0]        cmd_hold;

  modport master (output cmd_valid, output cmd_level, output cmd_hold, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_level, input  cmd_hold, output cmd_ready);
endinterface

// File: rtl/pwm_cmd_fifo.sv
// Show-ahead command queue: head entry is always visible on o_data, flush empties it in one edge.
module pwm_cmd_fifo
  import pwm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic i_push,
  input  logic i_pop,
  input  logic i_flush,
  input  cmd_t i_data,
  output cmd_t o_data,
  output logic o_full,
  output logic o_empty
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

  cmd_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the count gates every read, so stale entries are never seen.
  always_ff @(posedge CLK) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/pwm_level_sequencer.sv
// Queued (level, hold) commands slewed onto a PWM level that only changes at period boundaries.
module pwm_level_sequencer
  import pwm_pkg::*;
#(
  parameter int PWM_UNIT   = PWM_UNIT_DEF,
  parameter int PWM_STEPS  = PWM_STEPS_DEF,
  parameter int MAX_LEVEL  = MAX_LEVEL_DEF,
  parameter int SLEW_STEP  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    enable,
  pwm_level_sequencer_if.slave    cmd_if,
  output logic signed [5:0]       level_out,
  output logic                    period_tick,
  output logic                    busy,
  output logic                    sat_flag
);

  localparam int                PERIOD = PWM_UNIT * PWM_STEPS;
  localparam int                PW     = $clog2(PERIOD);
  localparam logic [7:0]        SLEW8  = 8'(SLEW_STEP);
  localparam logic signed [7:0] MAX8   = 8'(MAX_LEVEL);

  logic [PW-1:0]     r_pcnt;
  logic              r_tick;
  state_t            r_state, w_state_nxt;
  logic signed [5:0] r_level, w_level_nxt;
  logic signed [5:0] r_tgt, w_tgt_nxt;
  logic [7:0]        r_hold, w_hold_nxt;
  logic              r_sat;
  logic              w_take, w_pop, w_push, w_full, w_empty;
  logic signed [5:0] w_stepped;
  cmd_t              w_head, w_push_cmd;

  assign cmd_if.cmd_ready = !w_full && enable && !RESET;
  assign w_push           = cmd_if.cmd_valid && cmd_if.cmd_ready;
  assign w_push_cmd       = '{level: clamp_level(cmd_if.cmd_level, MAX8),
                              hold:  (cmd_if.cmd_hold == 8'd0) ? 8'd1 : cmd_if.cmd_hold};

  pwm_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (!enable),
    .i_data  (w_push_cmd),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Tick is registered one count early so it is high exactly while pcnt == PERIOD-1.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pcnt <= '0;
      r_tick <= 1'b0;
    end else begin
      r_pcnt <= (r_pcnt == PW'(PERIOD-1)) ? '0 : r_pcnt + 1'b1;
      r_tick <= (r_pcnt == PW'(PERIOD-2));
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    w_tgt_nxt   = r_tgt;
    w_hold_nxt  = r_hold;
    w_take      = 1'b0;
    w_pop       = 1'b0;
    w_stepped   = step_level(r_level, r_tgt, SLEW8);
    if (!enable) begin
      w_state_nxt = IDLE;
      if (r_tick) w_level_nxt = step_level(r_level, 6'sd0, SLEW8);
    end else if (r_tick) begin
      case (r_state)
        IDLE: w_take = !w_empty;
        RAMP: begin
          w_level_nxt = w_stepped;
          if (w_stepped == r_tgt) w_state_nxt = HOLD;
        end
        HOLD: begin
          if (r_hold > 8'd1)  w_hold_nxt  = r_hold - 8'd1;
          else if (!w_empty)  w_take      = 1'b1;
          else                w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
      if (w_take) begin
        w_pop       = 1'b1;
        w_tgt_nxt   = w_head.level;
        w_hold_nxt  = w_head.hold;
        w_level_nxt = step_level(r_level, w_head.level, SLEW8);
        w_state_nxt = (w_level_nxt == w_head.level) ? HOLD : RAMP;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
      r_level <= '0;
      r_tgt   <= '0;
      r_hold  <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_level <= w_level_nxt;
      r_tgt   <= w_tgt_nxt;
      r_hold  <= w_hold_nxt;
      r_sat   <= r_sat | (w_push && is_clamped(cmd_if.cmd_level, MAX8));
    end
  end

  assign level_out   = r_level;
  assign period_tick = r_tick;
  assign busy        = (r_state != IDLE) || !w_empty;
  assign sat_flag    = r_sat;

endmodule

// File: tb/tb_pwm_level_sequencer.sv
// Randomized bench for pwm_level_sequencer, checked every cycle against a queue-based behavioural model.
module tb_pwm_level_sequencer;

  localparam int PWM_UNIT   = 2;
  localparam int PWM_STEPS  = 15;
  localparam int PERIOD     = PWM_UNIT * PWM_STEPS;
  localparam int MAX_LEVEL  = 15;
  localparam int SLEW_STEP  = 1;
  localparam int FIFO_DEPTH = 4;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              enable;
  logic signed [5:0] level_out;
  logic              period_tick;
  logic              busy;
  logic              sat_flag;

  pwm_level_sequencer_if ifc();

  pwm_level_sequencer #(
    .PWM_UNIT   (PWM_UNIT),
    .PWM_STEPS  (PWM_STEPS),
    .MAX_LEVEL  (MAX_LEVEL),
    .SLEW_STEP  (SLEW_STEP),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .enable      (enable),
    .cmd_if      (ifc),
    .level_out   (level_out),
    .period_tick (period_tick),
    .busy        (busy),
    .sat_flag    (sat_flag)
  );

  always #5 CLK = ~CLK;

  // Model: a command queue plus "current job" bookkeeping, advanced once per clock edge.
  typedef struct { int lvl; int hold; } mcmd_t;
  mcmd_t m_q[$];
  int    m_pcnt, m_level, m_tgt, m_hold_left;
  bit    m_active, m_holding, m_sat;
  bit    last_accept;
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
  endtask

  function automatic int m_step(input int l, input int t);
    int d = t - l;
    if (d > SLEW_STEP)  return l + SLEW_STEP;
    if (d < -SLEW_STEP) return l - SLEW_STEP;
    return t;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pcnt = 0; m_level = 0; m_tgt = 0; m_hold_left = 0;
    m_active = 0; m_holding = 0; m_sat = 0;
  endtask

  task automatic model_edge(input bit rst, input bit en, input bit accept, input int lvl, input int hold);
    bit    tick;
    bit    take;
    mcmd_t c;
    if (rst) begin
      model_reset();
      return;
    end
    tick = (m_pcnt == PERIOD - 1);
    take = 0;
    if (!en) begin
      m_q.delete();
      m_active = 0;
      if (tick) m_level = m_step(m_level, 0);
    end else if (tick) begin
      if (!m_active)              take = (m_q.size() > 0);
      else if (!m_holding) begin
        m_level = m_step(m_level, m_tgt);
        if (m_level == m_tgt) m_holding = 1;
      end
      else if (m_hold_left > 1)   m_hold_left--;
      else if (m_q.size() > 0)    take = 1;
      else                        m_active = 0;
      if (take) begin
        c = m_q.pop_front();
        m_tgt       = c.lvl;
        m_hold_left = c.hold;
        m_level     = m_step(m_level, m_tgt);
        m_active    = 1;
        m_holding   = (m_level == m_tgt);
      end
    end
    if (accept) begin
      c.lvl  = (lvl > MAX_LEVEL) ? MAX_LEVEL : (lvl < -MAX_LEVEL) ? -MAX_LEVEL : lvl;
      c.hold = (hold == 0) ? 1 : hold;
      if (c.lvl != lvl) m_sat = 1;
      m_q.push_back(c);
    end
    m_pcnt = (m_pcnt + 1) % PERIOD;
  endtask

  // One clock: drive inputs after the falling edge, compare outputs, then advance the model.
  task automatic drive_cycle(input bit rst, input bit en, input bit valid, input int lvl, input int hold);
    bit exp_ready;
    @(negedge CLK);
    RESET         = rst;
    enable        = en;
    ifc.cmd_valid = valid;
    ifc.cmd_level = 8'(lvl);
    ifc.cmd_hold  = 8'(hold);
    #1;
    exp_ready = !rst && en && (m_q.size() < FIFO_DEPTH);
    check("period_tick", int'(period_tick), int'(m_pcnt == PERIOD - 1));
    check("level_out",   int'(level_out),   m_level);
    check("busy",        int'(busy),        int'(m_active || m_q.size() != 0));
    check("sat_flag",    int'(sat_flag),    int'(m_sat));
    check("cmd_ready",   int'(ifc.cmd_ready), int'(exp_ready));
    last_accept = valid && exp_ready;
    model_edge(rst, en, last_accept, lvl, hold);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive_cycle(0, 1, 0, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)));
  endtask

  task automatic send(input int lvl, input int hold);
    int waited = 0;
    do begin
      drive_cycle(0, 1, 1, lvl, hold);
      waited++;
    end while (!last_accept && waited < 2000);
    check("send_accepted", int'(last_accept), 1);
  endtask

  // Advance until the upcoming cycle is mid-period, so an enable drop never coincides with a tick.
  task automatic goto_mid_period();
    int guard = 0;
    while (!(m_pcnt >= 5 && m_pcnt <= 20) && guard < PERIOD) begin
      idle(1);
      guard++;
    end
  endtask

  task automatic drain();
    int guard = 0;
    while ((m_active || m_q.size() != 0) && guard < 5000) begin
      idle(1);
      guard++;
    end
    check("drain_timeout", int'(m_active || m_q.size() != 0), 0);
  endtask

  initial begin
    int guard;
    int r;
    RESET = 1'b1; enable = 1'b0;
    ifc.cmd_valid = 1'b0; ifc.cmd_level = '0; ifc.cmd_hold = '0;
    model_reset();

    repeat (3) drive_cycle(1, 0, 0, 0, 0);

    // Single ramp to 5 with hold 2.
    send(5, 2);
    idle(9 * PERIOD);

    // Down through zero, then back up with no gap period.
    send(-3, 1);
    send(0, 1);
    idle(12 * PERIOD);

    // Saturating targets; hold 0 behaves as 1.
    send(100, 1);
    send(-128, 0);
    drain();

    // Five back-to-back pushes: the fifth stalls on a full queue.
    for (int i = 0; i < 5; i++)
      send(int'($urandom_range(0, 12)) - 6, int'($urandom_range(0, 2)));
    drain();

    // Drop enable mid-RAMP at level 7 with commands still being offered.
    send(12, 1);
    guard = 0;
    while (!(m_level == 7 && m_active && !m_holding && m_pcnt == 10) && guard < 3000) begin
      idle(1);
      guard++;
    end
    check("reach_level7", m_level, 7);
    repeat (10 * PERIOD)
      drive_cycle(0, 0, 1, int'($urandom_range(0, 30)) - 15, int'($urandom_range(0, 3)));
    idle(PERIOD);

    // RESET one cycle before a tick while ramping.
    send(-10, 1);
    guard = 0;
    while (!(m_active && !m_holding && m_pcnt == PERIOD - 2) && guard < 3000) begin
      idle(1);
      guard++;
    end
    check("reach_ramp_pre_tick", m_pcnt, PERIOD - 2);
    drive_cycle(1, 1, 0, 0, 0);
    idle(3 * PERIOD);

    // Random mix of commands, gaps and enable drops.
    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(0, 7));
      if (r == 0) begin
        goto_mid_period();
        repeat ($urandom_range(30, 120))
          drive_cycle(0, 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 3)));
      end else begin
        if (r <= 2) send(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 3)));
        else        send(int'($urandom_range(0, 16)) - 8,   int'($urandom_range(0, 3)));
        idle(int'($urandom_range(0, 60)));
      end
    end
    drain();
    idle(2 * PERIOD);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
